// File: rtl/duc_factor_pkg.sv
// Shared definitions for the DUC factor-table loader: word width, idle address,
// default tap count and loader FSM state encodings.
package duc_factor_pkg;

  localparam int          DUC_FACTOR_W         = 16;
  localparam int          DUC_FACTOR_NUM_TAPS  = 20;
  localparam logic [15:0] DUC_FACTOR_IDLE_ADDR = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_WAIT,
    ST_HOLD,
    ST_FIN,
    ST_ABORT
  } dfl_state_t;

endpackage

// File: rtl/dfl_cycle_timer.sv
// Loadable down-counter with terminal-count flag; times the table-clear pulse
// and the per-word hold window of the DUC factor loader.
module dfl_cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/duc_factor_loader.sv
// Host-side writer for the DUC interpolation-factor table: clears the table, then
// writes NUM_TAPS streamed coefficients. Optional running checksum: DUC_FACTOR_CHECKSUM_EN.
module duc_factor_loader
  import duc_factor_pkg::*;
#(
  parameter int          NUM_TAPS    = DUC_FACTOR_NUM_TAPS,
  parameter int          RST_CYCLES  = 8,
  parameter int          HOLD_CYCLES = 4,
  parameter logic [15:0] IDLE_ADDR   = DUC_FACTOR_IDLE_ADDR
) (
  input  logic                           clkin,
  input  logic                           reset,
  input  logic                           load_start,
  input  logic                           load_abort,
  input  logic                           coef_valid,
  input  logic signed [DUC_FACTOR_W-1:0] coef_data,
  output logic                           coef_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           aborted,
  output logic        [DUC_FACTOR_W-1:0] checksum,
  output logic        [15:0]             DUC_Factor_WR_Addr,
  output logic signed [DUC_FACTOR_W-1:0] DUC_Factor_WR_Data,
  output logic                           DUC_Factor_WR_Rst
);

  localparam logic [15:0] RST_LOAD  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] LAST_TAP  = 16'(NUM_TAPS - 1);

  dfl_state_t  state;
  logic [15:0] tap_cnt;
  logic        tmr_load;
  logic [15:0] tmr_val;
  logic [15:0] tmr_cnt;
  logic        tmr_tc;
  logic        abort_req;
  logic        xfer;

  // An abort beats a same-cycle transfer, so the word offered then is not taken.
  assign abort_req = load_abort &&
                     ((state == ST_CLR) || (state == ST_WAIT) || (state == ST_HOLD));
  assign xfer      = (state == ST_WAIT) && coef_valid && coef_ready && !load_abort;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = RST_LOAD;
    if (state == ST_IDLE && load_start) begin
      tmr_load = 1'b1;
    end else if (abort_req) begin
      tmr_load = 1'b1;
    end else if (xfer) begin
      tmr_load = 1'b1;
      tmr_val  = HOLD_LOAD;
    end
  end

  dfl_cycle_timer #(.W(16)) u_timer (
    .clk      (clkin),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      tap_cnt            <= '0;
      coef_ready         <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      aborted            <= 1'b0;
      DUC_Factor_WR_Addr <= IDLE_ADDR;
      DUC_Factor_WR_Data <= '0;
      DUC_Factor_WR_Rst  <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort_req) begin
        state              <= ST_ABORT;
        coef_ready         <= 1'b0;
        DUC_Factor_WR_Addr <= IDLE_ADDR;
        DUC_Factor_WR_Rst  <= 1'b1;
        aborted            <= (RST_CYCLES == 1);
      end else begin
        case (state)
          ST_IDLE: begin
            if (load_start) begin
              state             <= ST_CLR;
              busy              <= 1'b1;
              tap_cnt           <= '0;
              DUC_Factor_WR_Rst <= 1'b1;
            end
          end
          ST_CLR: begin
            if (tmr_tc) begin
              state             <= ST_WAIT;
              DUC_Factor_WR_Rst <= 1'b0;
              coef_ready        <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (xfer) begin
              state              <= ST_HOLD;
              coef_ready         <= 1'b0;
              DUC_Factor_WR_Addr <= tap_cnt;
              DUC_Factor_WR_Data <= coef_data;
            end
          end
          ST_HOLD: begin
            if (tmr_tc) begin
              DUC_Factor_WR_Addr <= IDLE_ADDR;
              tap_cnt            <= tap_cnt + 16'd1;
              if (tap_cnt == LAST_TAP) begin
                state <= ST_FIN;
                done  <= 1'b1;
              end else begin
                state      <= ST_WAIT;
                coef_ready <= 1'b1;
              end
            end
          end
          ST_FIN: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          ST_ABORT: begin
            // aborted is registered, so it is raised one count early to land on the last cycle.
            if (tmr_tc) begin
              state             <= ST_IDLE;
              busy              <= 1'b0;
              DUC_Factor_WR_Rst <= 1'b0;
            end else begin
              aborted <= (tmr_cnt == 16'd1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef DUC_FACTOR_CHECKSUM_EN
  function automatic logic [DUC_FACTOR_W-1:0] wrap_add(input logic [DUC_FACTOR_W-1:0] a,
                                                       input logic [DUC_FACTOR_W-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (state == ST_IDLE && load_start) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= wrap_add(checksum, coef_data);
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_duc_factor_loader.sv
// Scoreboard bench for duc_factor_loader: accepted words are queued by the driver
// and matched against the DUC write bus by a negedge monitor.
module tb_duc_factor_loader;

  localparam int NT   = 20;
  localparam int RSTC = 8;
  localparam int HOLD = 4;
  localparam int BUDGET = 2000;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } sb_t;

  logic        clkin = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        load_abort = 1'b0;
  logic        coef_valid = 1'b0;
  logic [15:0] coef_data = 16'h0;
  logic        coef_ready;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] checksum;
  logic [15:0] DUC_Factor_WR_Addr;
  logic [15:0] DUC_Factor_WR_Data;
  logic        DUC_Factor_WR_Rst;

  int tests_run = 0;
  int tests_failed = 0;
  sb_t sb[$];
  int rst_run = 0;
  int word_len = 0;
  int load_words = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic [15:0] prev_addr = 16'hFFFF;
  logic [15:0] held_data = 16'h0;

  duc_factor_loader dut (
    .clkin              (clkin),
    .reset              (reset),
    .load_start         (load_start),
    .load_abort         (load_abort),
    .coef_valid         (coef_valid),
    .coef_data          (coef_data),
    .coef_ready         (coef_ready),
    .busy               (busy),
    .done               (done),
    .aborted            (aborted),
    .checksum           (checksum),
    .DUC_Factor_WR_Addr (DUC_Factor_WR_Addr),
    .DUC_Factor_WR_Data (DUC_Factor_WR_Data),
    .DUC_Factor_WR_Rst  (DUC_Factor_WR_Rst)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: clear pulse length, word hold length, idle gaps, scoreboard match.
  always @(negedge clkin) begin
    if (!reset) begin
      rst_run   = 0;
      word_len  = 0;
      prev_addr = 16'hFFFF;
    end else begin
      if (DUC_Factor_WR_Rst) begin
        rst_run++;
      end else begin
        if (rst_run != 0) chk("rst_len", rst_run, RSTC);
        rst_run = 0;
      end
      if (aborted) begin
        abort_cnt++;
        chk("abort_pos", rst_run, RSTC);
      end
      if (done) begin
        done_cnt++;
        chk("done_words", load_words, NT);
        chk("done_addr", DUC_Factor_WR_Addr, 16'hFFFF);
      end
      if (DUC_Factor_WR_Addr != 16'hFFFF) begin
        if (prev_addr == 16'hFFFF) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected", DUC_Factor_WR_Addr, 16'hFFFF);
          end else begin
            sb_t e;
            e = sb.pop_front();
            chk("addr", DUC_Factor_WR_Addr, e.addr);
            chk("data", DUC_Factor_WR_Data, e.data);
          end
          load_words++;
          held_data = DUC_Factor_WR_Data;
          word_len  = 1;
        end else begin
          chk("addr_stable", DUC_Factor_WR_Addr, prev_addr);
          chk("data_stable", DUC_Factor_WR_Data, held_data);
          word_len++;
        end
      end else if (word_len != 0) begin
        if (!DUC_Factor_WR_Rst) chk("hold_len", word_len, HOLD);
        word_len = 0;
      end
      prev_addr = DUC_Factor_WR_Addr;
    end
  end

  // mode 0: valid always high, mode 1: random valid.
  task automatic run_load(input int mode, input int abort_at, input int start_at,
                          input logic [15:0] base);
    int idx = 0;
    int d0 = done_cnt;
    int a0 = abort_cnt;
    int ab_cyc = -10;
    bit finished = 0;
    bit pulsed = 0;
    bit armed = 0;
    bit ab_done = 0;
    logic [15:0] exp_sum = 16'h0;
    load_words = 0;
    @(posedge clkin); #1 load_start = 1'b1;
    @(posedge clkin); #1 load_start = 1'b0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      coef_data  = base + 16'(idx);
      coef_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      load_start = 1'b0;
      load_abort = 1'b0;
      if (start_at >= 0 && idx == start_at && !pulsed) begin
        if (armed) begin
          load_start = 1'b1;
          pulsed = 1;
        end else begin
          coef_valid = 1'b0;
        end
      end
      if (abort_at >= 0 && idx == abort_at + 1 && !ab_done) begin
        load_abort = 1'b1;
        ab_done = 1;
        ab_cyc = cyc;
      end
      @(negedge clkin);
      if (cyc == ab_cyc + 1) begin
        chk("abort_addr", DUC_Factor_WR_Addr, 16'hFFFF);
        chk("abort_rst", DUC_Factor_WR_Rst, 1'b1);
      end
      if (start_at >= 0 && idx == start_at && coef_ready && !pulsed) armed = 1;
      if (coef_valid && coef_ready && !load_abort) begin
        sb.push_back({16'(idx), coef_data});
        exp_sum = exp_sum + coef_data;
        idx++;
      end
      if (!busy) begin
        finished = 1;
        break;
      end
      @(posedge clkin); #1;
    end
    coef_valid = 1'b0;
    load_start = 1'b0;
    load_abort = 1'b0;
    if (!finished) chk("timeout_busy", busy, 1'b0);
    if (abort_at >= 0) begin
      chk("abort_done_cnt", done_cnt - d0, 0);
      chk("abort_cnt", abort_cnt - a0, 1);
      chk("abort_words", load_words, abort_at + 1);
      sb.delete();
    end else begin
      chk("done_cnt", done_cnt - d0, 1);
      chk("abort_cnt0", abort_cnt - a0, 0);
      chk("words", load_words, NT);
      chk("sb_left", sb.size(), 0);
`ifdef DUC_FACTOR_CHECKSUM_EN
      chk("checksum", checksum, exp_sum);
`else
      chk("checksum", checksum, 16'h0);
`endif
    end
    repeat (3) @(posedge clkin);
  endtask

  initial begin
    repeat (3) @(posedge clkin);
    @(negedge clkin) reset = 1'b1;
    // idle after reset
    repeat (10) @(posedge clkin);
    @(negedge clkin);
    chk("idle_addr", DUC_Factor_WR_Addr, 16'hFFFF);
    chk("idle_rst", DUC_Factor_WR_Rst, 1'b0);
    chk("idle_ready", coef_ready, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_data", DUC_Factor_WR_Data, 16'h0);
    chk("idle_checksum", checksum, 16'h0);

    run_load(0, -1, -1, 16'h0001);
`ifdef DUC_FACTOR_CHECKSUM_EN
    chk("checksum_d2", checksum, 16'h00D2);
`endif
    run_load(1, -1, -1, 16'h0001);
    run_load(0, 7, -1, 16'h0001);
    chk("abort_busy_low", busy, 1'b0);
    run_load(0, -1, 3, 16'h0001);

    // asynchronous reset while clearing the table
    @(posedge clkin); #1 load_start = 1'b1;
    @(posedge clkin); #1 load_start = 1'b0;
    repeat (3) @(posedge clkin);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rst", DUC_Factor_WR_Rst, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_addr", DUC_Factor_WR_Addr, 16'hFFFF);
    chk("mid_rst_ready", coef_ready, 1'b0);
    sb.delete();
    repeat (2) @(posedge clkin);
    @(negedge clkin) reset = 1'b1;
    run_load(0, -1, -1, 16'hFFF0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
